// File: rtl/seven_segment_scan_controller.sv
// Scans a w_digit-position common-anode seven-segment display with blanking and a
// double-buffered valid/ready update path. Optional: SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN.
module seven_segment_scan_controller #(
  parameter int unsigned w_digit      = 8,
  parameter int unsigned digit_cycles = 100000,
  parameter int unsigned blank_cycles = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   upd_valid,
  input  logic [4*w_digit-1:0]   upd_data,
  input  logic [w_digit-1:0]     upd_dots,
  output logic                   upd_ready,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic [w_digit-1:0]     an,
  output logic                   frame_done
);

  localparam int unsigned CntW = (digit_cycles > 1) ? $clog2(digit_cycles) : 1;
  localparam int unsigned IdxW = (w_digit > 1) ? $clog2(w_digit) : 1;

  localparam logic [CntW-1:0] CntLast  = CntW'(digit_cycles - 1);
  localparam logic [CntW-1:0] CntBlank = CntW'(blank_cycles);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(w_digit - 1);

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [4*w_digit-1:0] act_data_q, act_data_d;
  logic [w_digit-1:0]   act_dots_q, act_dots_d;
  logic [4*w_digit-1:0] shd_data_q, shd_data_d;
  logic [w_digit-1:0]   shd_dots_q, shd_dots_d;
  logic                 pending_q, pending_d;

  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [w_digit-1:0]   an_q, an_d;
  logic                 frame_done_q, frame_done_d;

  logic                 slot_end;
  logic                 boundary;
  logic                 xfer;
  logic [3:0]           cur_nib;
  logic                 cur_dot;
  logic                 digit_en;
  logic                 drive;

  // Active-high segment pattern {g,f,e,d,c,b,a}; b and d are lowercase glyphs.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign upd_ready = ~pending_q;

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

  // Scan schedule and double-buffer bookkeeping.
  always_comb begin
    slot_end = (cnt_q == CntLast);
    boundary = slot_end && (idx_q == IdxLast);
    xfer     = upd_valid && !pending_q;

    cnt_d = slot_end ? '0 : cnt_q + CntW'(1);
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end

    act_data_d = act_data_q;
    act_dots_d = act_dots_q;
    shd_data_d = shd_data_q;
    shd_dots_d = shd_dots_q;
    pending_d  = pending_q;

    // Only an update pending before the boundary is promoted; a same-cycle
    // transfer cannot collide because it requires pending_q to be clear.
    if (boundary && pending_q) begin
      act_data_d = shd_data_q;
      act_dots_d = shd_dots_q;
      pending_d  = 1'b0;
    end
    if (xfer) begin
      shd_data_d = upd_data;
      shd_dots_d = upd_dots;
      pending_d  = 1'b1;
    end
  end

  assign cur_nib = act_data_q[{idx_q, 2'b00} +: 4];
  assign cur_dot = act_dots_q[idx_q];

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
  logic [IdxW-1:0] hi_idx;

  // Highest nonzero nibble; digit 0 is the floor so all-zero data shows "0".
  always_comb begin
    hi_idx = '0;
    for (int i = 1; i < int'(w_digit); i++) begin
      if (act_data_q[4*i +: 4] != 4'h0) begin
        hi_idx = IdxW'(i);
      end
    end
  end

  assign digit_en = (idx_q <= hi_idx) || cur_dot;
`else
  assign digit_en = 1'b1;
`endif

  // Output decode; registered so the pins change one cycle after the state.
  always_comb begin
    drive        = (cnt_q >= CntBlank) && digit_en;
    an_d         = '1;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    frame_done_d = boundary;
    if (drive) begin
      an_d  = ~(w_digit'(1) << idx_q);
      seg_d = ~hex_to_seg(cur_nib);
      dp_d  = ~cur_dot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_dots_q   <= '0;
      shd_data_q   <= '0;
      shd_dots_q   <= '0;
      pending_q    <= 1'b0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_dots_q   <= act_dots_d;
      shd_data_q   <= shd_data_d;
      shd_dots_q   <= shd_dots_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for seven_segment_scan_controller (4 digits, 8-cycle slots, 2 blank cycles).
module tb_seven_segment_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_valid;
  logic [15:0] upd_data;
  logic [3:0]  upd_dots;
  logic        upd_ready;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int          checks = 0;
  int          errors = 0;
  int          k;
  logic [15:0] exp_data;
  logic [3:0]  exp_dots;
  logic        exp_rdy;

  seven_segment_scan_controller #(
    .w_digit      (4),
    .digit_cycles (8),
    .blank_cycles (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .upd_valid  (upd_valid),
    .upd_data   (upd_data),
    .upd_dots   (upd_dots),
    .upd_ready  (upd_ready),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Active-low glyphs as they should appear on the seg pins.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s k=%0d got %b exp %b", tag, k, got, want);
    end
  endtask

  task automatic check_reset();
    chk("rst_an", {3'b000, an}, 7'b0001111);
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_dp", {6'b0, dp}, 7'd1);
    chk("rst_fd", {6'b0, frame_done}, 7'd0);
    chk("rst_rdy", {6'b0, upd_ready}, 7'd1);
  endtask

  // One clock, then compare all outputs against the scan position k.
  task automatic cycle_chk();
    int         pos;
    int         d;
    int         hi;
    logic       lit;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    @(posedge clk);
    #1;
    k++;
    pos = k % 8;
    d   = (k / 8) % 4;
    hi  = 0;
    lit = 1'b1;
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    for (int i = 1; i < 4; i++) begin
      if (exp_data[4*i +: 4] != 4'h0) hi = i;
    end
    lit = (d <= hi) || exp_dots[d];
`endif
    if (pos < 2 || !lit) begin
      ea = 4'b1111;
      es = 7'b1111111;
      ed = 1'b1;
    end else begin
      ea = ~(4'b0001 << d);
      es = glyph(exp_data[4*d +: 4]);
      ed = ~exp_dots[d];
    end
    chk("an", {3'b000, an}, {3'b000, ea});
    chk("seg", seg, es);
    chk("dp", {6'b0, dp}, {6'b0, ed});
    chk("frame_done", {6'b0, frame_done}, {6'b0, (k % 32) == 31});
    chk("upd_ready", {6'b0, upd_ready}, {6'b0, exp_rdy});
  endtask

  task automatic run_to(input int t);
    while (k < t) cycle_chk();
  endtask

  initial begin
    rst       = 1'b1;
    upd_valid = 1'b0;
    upd_data  = 16'h0000;
    upd_dots  = 4'b0000;
    exp_data  = 16'h0000;
    exp_dots  = 4'b0000;
    exp_rdy   = 1'b1;
    k         = -1;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;

    // Idle scan of zeros.
    run_to(39);

    // Mid-frame update, shown after the next boundary.
    upd_valid = 1'b1;
    upd_data  = 16'h1A2F;
    upd_dots  = 4'b0010;
    exp_rdy   = 1'b0;
    cycle_chk();
    upd_valid = 1'b0;
    run_to(62);
    exp_rdy = 1'b1;
    cycle_chk();
    exp_data = 16'h1A2F;
    exp_dots = 4'b0010;
    run_to(126);

    // Transfer on the boundary cycle is deferred one frame.
    upd_valid = 1'b1;
    upd_data  = 16'h0005;
    upd_dots  = 4'b0000;
    exp_rdy   = 1'b0;
    cycle_chk();
    upd_valid = 1'b0;
    run_to(158);
    exp_rdy = 1'b1;
    cycle_chk();
    exp_data = 16'h0005;
    exp_dots = 4'b0000;

    // Held valid while pending must not overwrite the shadow.
    upd_valid = 1'b1;
    upd_data  = 16'h0007;
    exp_rdy   = 1'b0;
    cycle_chk();
    upd_data = 16'h1111;
    run_to(190);
    exp_rdy = 1'b1;
    cycle_chk();
    exp_data = 16'h0007;
    exp_rdy  = 1'b0;
    cycle_chk();
    upd_valid = 1'b0;
    run_to(222);
    exp_rdy = 1'b1;
    cycle_chk();
    exp_data = 16'h1111;
    run_to(255);

    // Reset in slot 2 with an update pending.
    upd_valid = 1'b1;
    upd_data  = 16'hABCD;
    upd_dots  = 4'b1111;
    exp_rdy   = 1'b0;
    cycle_chk();
    upd_valid = 1'b0;
    run_to(273);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset();
    rst      = 1'b0;
    k        = -1;
    exp_data = 16'h0000;
    exp_dots = 4'b0000;
    exp_rdy  = 1'b1;
    run_to(40);

    // Leading-zero content: 0030, then 0000.
    upd_valid = 1'b1;
    upd_data  = 16'h0030;
    upd_dots  = 4'b0000;
    exp_rdy   = 1'b0;
    cycle_chk();
    upd_valid = 1'b0;
    run_to(62);
    exp_rdy = 1'b1;
    cycle_chk();
    exp_data = 16'h0030;
    run_to(70);
    upd_valid = 1'b1;
    upd_data  = 16'h0000;
    exp_rdy   = 1'b0;
    cycle_chk();
    upd_valid = 1'b0;
    run_to(94);
    exp_rdy = 1'b1;
    cycle_chk();
    exp_data = 16'h0000;
    run_to(127);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
